serial_add_ctrl: RTL and testbench

Bit-serial adder sequencer. Latches two WIDTH-bit operands on a start pulse, then drives a single 1-bit adder cell (two half adders plus an OR) one bit per clock, LSB first, with a carry register between cycles. Collects sum bits in a shift register and signals completion with a one-cycle done pulse. Trades WIDTH cycles of latency for one adder cell of area; it is the sequencing front-end for the team's half-adder datapath.

---
 rtl/serial_add_pkg.sv | 13 +
 rtl/serial_add_ctrl_fa_cell.sv | 32 +++
 rtl/serial_add_ctrl.sv | 124 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder sequencer: FSM state encoding
// and the default operand width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// 1-bit full adder cell for the serial adder, built from two half adders
// and an OR gate on the two partial carries.
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_a ^ i_b;
  assign o_carry = i_a & i_b;

endmodule

module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder u_ha0 (.i_a(i_a),  .i_b(i_b),   .o_sum(w_s0),  .o_carry(w_c0));
  half_adder u_ha1 (.i_a(w_s0), .i_b(i_cin), .o_sum(o_sum), .o_carry(w_c1));

  assign o_cout = w_c0 | w_c1;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell, LSB first, WIDTH cycles per sum.
// Build option SERIAL_ADD_SUB_EN adds two's-complement subtract via the sub input.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int  WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_count;
  logic             r_carry;
  logic             r_carry_out;
  logic             r_busy;
  logic             r_done;
  logic             w_accept;
  logic             w_last;
  logic             w_s;
  logic             w_c;
  logic             w_sub;

`ifdef SERIAL_ADD_SUB_EN
  assign w_sub = sub;
`else
  logic w_unused_sub;
  assign w_unused_sub = sub;
  assign w_sub        = 1'b0;
`endif

  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last   = (r_count == CNT_W'(WIDTH - 1));

  fa_cell u_fa (
    .i_a   (r_op_a[0]),
    .i_b   (r_op_b[0]),
    .i_cin (r_carry),
    .o_sum (w_s),
    .o_cout(w_c)
  );

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_RUN;
        else       w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (w_last) w_state_nxt = ST_DONE;
        else        w_state_nxt = ST_RUN;
      end
      ST_DONE: begin
        if (start) w_state_nxt = ST_RUN;
        else       w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, datapath shift registers and result holding registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_shift     <= '0;
      r_sum       <= '0;
      r_count     <= '0;
      r_carry     <= 1'b0;
      r_carry_out <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
      if (w_accept) begin
        // Subtract is a + ~b + 1: invert B and seed the carry with 1.
        r_op_a  <= a;
        r_op_b  <= b ^ {WIDTH{w_sub}};
        r_carry <= w_sub;
        r_count <= '0;
      end else if (r_state == ST_RUN) begin
        r_op_a  <= {1'b0, r_op_a[WIDTH-1:1]};
        r_op_b  <= {1'b0, r_op_b[WIDTH-1:1]};
        r_shift <= {w_s, r_shift[WIDTH-1:1]};
        r_carry <= w_c;
        r_count <= r_count + CNT_W'(1);
        if (w_last) begin
          r_sum       <= {w_s, r_shift[WIDTH-1:1]};
          r_carry_out <= w_c;
        end else begin
          r_sum       <= r_sum;
          r_carry_out <= r_carry_out;
        end
      end else begin
        r_count <= r_count;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign sum       = r_sum;
  assign carry_out = r_carry_out;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8); expected
// sub results depend on whether SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       carry_out;

  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] prev_sum = 8'h00;
  logic       prev_co  = 1'b0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carry_out(carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge; start is accepted at the next edge.
  task automatic do_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                       input logic isub, input logic [7:0] exp_sum, input logic exp_co,
                       input bit glitch);
    int lat;
    int nbusy;
    a = ia; b = ib; sub = isub; start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'h00; b = 8'h00; sub = 1'b0;
    lat = 0;
    nbusy = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      if (lat == 3) begin
        chk({tag, "_held_sum"}, {24'h0, sum}, {24'h0, prev_sum});
        chk({tag, "_held_co"}, {31'h0, carry_out}, {31'h0, prev_co});
      end
      if (glitch && lat == 2) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF; sub = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    chk({tag, "_done"}, {31'h0, done}, 32'h1);
    chk({tag, "_latency"}, lat + 1, 32'd9);
    chk({tag, "_busy_cycles"}, nbusy, 32'd8);
    chk({tag, "_busy_in_done"}, {31'h0, busy}, 32'h0);
    chk({tag, "_sum"}, {24'h0, sum}, {24'h0, exp_sum});
    chk({tag, "_co"}, {31'h0, carry_out}, {31'h0, exp_co});
    prev_sum = exp_sum;
    prev_co  = exp_co;
  endtask

  task automatic idle_check(input string tag);
    tick();
    chk({tag, "_done_pulse_ends"}, {31'h0, done}, 32'h0);
    chk({tag, "_idle_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_idle_sum"}, {24'h0, sum}, {24'h0, prev_sum});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; sub = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_sum", {24'h0, sum}, 32'h0);
    chk("rst_co", {31'h0, carry_out}, 32'h0);

    do_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    idle_check("zero");
    do_op("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    idle_check("ff_01");
    do_op("a5_5a", 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0);
    do_op("b2b", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    idle_check("b2b");
    do_op("ignore_mid", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1);
    idle_check("ignore_mid");
    do_op("ff_ff", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0);
    idle_check("ff_ff");
    do_op("12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    idle_check("12_34");

    // Asynchronous reset in the fourth RUN cycle, between clock edges.
    a = 8'h55; b = 8'h11; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_busy", {31'h0, busy}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_done", {31'h0, done}, 32'h0);
    chk("arst_sum", {24'h0, sum}, 32'h0);
    chk("arst_co", {31'h0, carry_out}, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_done", {31'h0, done}, 32'h0);
    prev_sum = 8'h00;
    prev_co  = 1'b0;
    do_op("7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0);
    idle_check("7f_01");

`ifdef SERIAL_ADD_SUB_EN
    do_op("sub_5_7", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    idle_check("sub_5_7");
    do_op("sub_7_5", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0);
    idle_check("sub_7_5");
`else
    do_op("sub_5_7", 8'h05, 8'h07, 1'b1, 8'h0C, 1'b0, 1'b0);
    idle_check("sub_5_7");
    do_op("sub_7_5", 8'h07, 8'h05, 1'b1, 8'h0C, 1'b0, 1'b0);
    idle_check("sub_7_5");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
